microcode_seq: RTL and testbench

- Parametrised, registered successor to the fixed opcode lookup table that feeds the nibble processor's datapath.
- Builds the lookup address from {opcode, flags, phase}. The phase bit is generated internally: 0 = fetch, 1 = execute.
- Matches the address against a runtime-loadable table of value/mask entries (don't-care support). The first hit wins.
- Presents the selected control word one clock later, with valid and miss indications. Sits between the instruction register/flag register and the datapath control lines.

---
 rtl/microcode_seq.sv | 106 ++++++++++
 tb/tb_microcode_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/microcode_seq.sv
// microcode_seq: masked first-hit control-word lookup with fetch/execute phase and registered outputs
module microcode_seq #(
  parameter int OPC_W = 4,
  parameter int FLAG_W = 2,
  parameter int CW_W = 13,
  parameter int ENTRIES = 24,
  parameter logic [CW_W-1:0] MISS_CW = '0,
  localparam int IDX_W = $clog2(ENTRIES),
  localparam int ADDR_W = OPC_W + FLAG_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              sync_clr,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [FLAG_W-1:0] flags,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_match,
  input  logic [ADDR_W-1:0] cfg_mask,
  input  logic [CW_W-1:0]   cfg_cw,
  input  logic              cfg_valid,
  output logic [CW_W-1:0]   cw,
  output logic              cw_valid,
  output logic              phase,
  output logic              miss,
  output logic              miss_sticky
);
  logic [ADDR_W-1:0] match_q [ENTRIES];
  logic [ADDR_W-1:0] match_d [ENTRIES];
  logic [ADDR_W-1:0] mask_q [ENTRIES];
  logic [ADDR_W-1:0] mask_d [ENTRIES];
  logic [CW_W-1:0]   word_q [ENTRIES];
  logic [CW_W-1:0]   word_d [ENTRIES];
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [ADDR_W-1:0] addr;
  logic [CW_W-1:0]   sel_cw;
  logic              hit;
  logic              phase_q, phase_d;
  logic [CW_W-1:0]   cw_q, cw_d;
  logic              cw_valid_q, cw_valid_d;
  logic              miss_q, miss_d;
  logic              miss_sticky_q, miss_sticky_d;
  // table write port; out-of-range rows are dropped
  always_comb begin
    match_d = match_q;
    mask_d  = mask_q;
    word_d  = word_q;
    valid_d = valid_q;
    if (cfg_we && int'(cfg_idx) < ENTRIES) begin
      match_d[cfg_idx] = cfg_match;
      mask_d[cfg_idx]  = cfg_mask;
      word_d[cfg_idx]  = cfg_cw;
      valid_d[cfg_idx] = cfg_valid;
    end
  end
  // row data needs no reset since valid bits gate every hit
  always_ff @(posedge clk) begin
    match_q <= match_d;
    mask_q  <= mask_d;
    word_q  <= word_d;
  end
  // descending scan so the lowest hitting row is the last to overwrite
  always_comb begin
    addr   = {opcode, flags, phase_q};
    hit    = 1'b0;
    sel_cw = MISS_CW;
    for (int r = ENTRIES - 1; r >= 0; r--) begin
      if (valid_q[r] && ((addr ^ match_q[r]) & mask_q[r]) == '0) begin
        hit    = 1'b1;
        sel_cw = word_q[r];
      end
    end
  end
  // sync_clr outranks en; cw is only replaced on an enabled lookup
  always_comb begin
    phase_d       = sync_clr ? 1'b0 : (en ? ~phase_q : phase_q);
    cw_d          = (en && !sync_clr) ? sel_cw : cw_q;
    cw_valid_d    = en && !sync_clr;
    miss_d        = sync_clr ? 1'b0 : (en ? ~hit : miss_q);
    miss_sticky_d = sync_clr ? 1'b0 : (miss_sticky_q | (en & ~hit));
  end
  // sequencer state and row valid bits, asynchronously cleared
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q       <= '0;
      phase_q       <= 1'b0;
      cw_q          <= '0;
      cw_valid_q    <= 1'b0;
      miss_q        <= 1'b0;
      miss_sticky_q <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      phase_q       <= phase_d;
      cw_q          <= cw_d;
      cw_valid_q    <= cw_valid_d;
      miss_q        <= miss_d;
      miss_sticky_q <= miss_sticky_d;
    end
  end
  assign cw          = cw_q;
  assign cw_valid    = cw_valid_q;
  assign phase       = phase_q;
  assign miss        = miss_q;
  assign miss_sticky = miss_sticky_q;
endmodule

// File: tb/tb_microcode_seq.sv
// tb_microcode_seq: directed and random checks of microcode_seq against a table-scan model
module tb_microcode_seq;
  localparam int ENTRIES = 24;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        sync_clr = 1'b0;
  logic [3:0]  opcode = '0;
  logic [1:0]  flags = '0;
  logic        cfg_we = 1'b0;
  logic [4:0]  cfg_idx = '0;
  logic [6:0]  cfg_match = '0;
  logic [6:0]  cfg_mask = '0;
  logic [12:0] cfg_cw = '0;
  logic        cfg_valid = 1'b0;
  logic [12:0] cw;
  logic        cw_valid, phase, miss, miss_sticky;
  int n_tests = 0;
  int n_fail = 0;
  typedef struct {
    logic [6:0]  m;
    logic [6:0]  k;
    logic [12:0] w;
    bit          v;
  } row_t;
  row_t        tab [ENTRIES];
  logic [12:0] m_cw;
  bit          m_valid, m_phase, m_miss, m_sticky;
  logic [12:0] held;

  microcode_seq dut (
    .clk(clk), .reset(reset), .en(en), .sync_clr(sync_clr),
    .opcode(opcode), .flags(flags),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_match(cfg_match),
    .cfg_mask(cfg_mask), .cfg_cw(cfg_cw), .cfg_valid(cfg_valid),
    .cw(cw), .cw_valid(cw_valid), .phase(phase), .miss(miss),
    .miss_sticky(miss_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".cw"}, 32'(cw), 32'(m_cw));
    check({tag, ".cw_valid"}, 32'(cw_valid), 32'(m_valid));
    check({tag, ".phase"}, 32'(phase), 32'(m_phase));
    check({tag, ".miss"}, 32'(miss), 32'(m_miss));
    check({tag, ".sticky"}, 32'(miss_sticky), 32'(m_sticky));
  endtask

  function automatic bit lookup(input logic [6:0] a, output logic [12:0] w);
    for (int r = 0; r < ENTRIES; r++)
      if (tab[r].v && ((a ^ tab[r].m) & tab[r].k) == 7'd0) begin
        w = tab[r].w;
        return 1'b1;
      end
    w = 13'd0;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < ENTRIES; r++) tab[r].v = 1'b0;
    m_cw = '0; m_valid = 0; m_phase = 0; m_miss = 0; m_sticky = 0;
  endtask

  task automatic cycle(input string tag);
    logic [12:0] w;
    bit h;
    h = lookup({opcode, flags, m_phase}, w);
    if (sync_clr) begin
      m_phase = 0; m_valid = 0; m_miss = 0; m_sticky = 0;
    end else if (en) begin
      m_cw = w; m_valid = 1; m_miss = !h; m_sticky = m_sticky | !h; m_phase = !m_phase;
    end else m_valid = 0;
    if (cfg_we && int'(cfg_idx) < ENTRIES)
      tab[cfg_idx] = '{m: cfg_match, k: cfg_mask, w: cfg_cw, v: cfg_valid};
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic write_row(input logic [4:0] idx, input logic [6:0] m, input logic [6:0] k,
                           input logic [12:0] w, input logic v);
    cfg_idx = idx; cfg_match = m; cfg_mask = k; cfg_cw = w; cfg_valid = v;
    cfg_we = 1'b1; en = 1'b0; sync_clr = 1'b0;
    cycle("wr");
    cfg_we = 1'b0;
  endtask

  task automatic goto_phase(input bit p);
    if (m_phase != p) begin
      en = 1'b1; sync_clr = 1'b0; cfg_we = 1'b0;
      cycle("step");
    end
  endtask

  initial begin
    model_reset();
    #2 reset = 1'b0;
    #1 check_all("rst");
    @(posedge clk);
    #2 reset = 1'b1;

    en = 1'b1;
    cycle("empty0");
    check("empty0.miss", 32'(miss), 32'd1);
    check("empty0.phase", 32'(phase), 32'd1);
    cycle("empty1");
    check("empty1.phase", 32'(phase), 32'd0);
    check("empty1.sticky", 32'(miss_sticky), 32'd1);

    write_row(5'd0, 7'b0000000, 7'b0000001, 13'h1008, 1'b1);
    write_row(5'd1, 7'b0010001, 7'b1111001, 13'h0A42, 1'b1);
    opcode = 4'b0010; flags = 2'b11; en = 1'b1;
    cycle("fetch");
    check("fetch.cw", 32'(cw), 32'h1008);
    check("fetch.miss", 32'(miss), 32'd0);
    cycle("exec");
    check("exec.cw", 32'(cw), 32'h0A42);
    check("exec.miss", 32'(miss), 32'd0);

    write_row(5'd2, 7'b1000011, 7'b1111011, 13'h0111, 1'b1);
    write_row(5'd5, 7'b1000001, 7'b1111001, 13'h0222, 1'b1);
    opcode = 4'b1000; flags = 2'b01;
    goto_phase(1'b1);
    en = 1'b1;
    cycle("prio");
    check("prio.cw", 32'(cw), 32'h0111);
    write_row(5'd2, 7'b1000011, 7'b1111011, 13'h0111, 1'b0);
    goto_phase(1'b1);
    en = 1'b1;
    cycle("prio_inv");
    check("prio_inv.cw", 32'(cw), 32'h0222);

    goto_phase(1'b1);
    held = cw;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle("hold");
      check("hold.cw", 32'(cw), 32'(held));
      check("hold.phase", 32'(phase), 32'd1);
    end
    en = 1'b1;
    cycle("resume1");
    check("resume1.cw", 32'(cw), 32'h0222);
    cycle("resume0");

    opcode = 4'b0010; flags = 2'b11;
    goto_phase(1'b1);
    cfg_idx = 5'd1; cfg_match = 7'b0010001; cfg_mask = 7'b1111001;
    cfg_cw = 13'h1555; cfg_valid = 1'b1; cfg_we = 1'b1; en = 1'b1;
    cycle("rdold");
    cfg_we = 1'b0;
    check("rdold.cw", 32'(cw), 32'h0A42);
    cycle("rdnew_f");
    cycle("rdnew");
    check("rdnew.cw", 32'(cw), 32'h1555);

    write_row(5'd24, 7'b0000000, 7'b0000000, 13'h1FFF, 1'b1);
    opcode = 4'b1111; flags = 2'b00;
    goto_phase(1'b1);
    en = 1'b1;
    cycle("oob");
    check("oob.miss", 32'(miss), 32'd1);

    goto_phase(1'b1);
    held = cw;
    sync_clr = 1'b1; en = 1'b1;
    cycle("sclr");
    sync_clr = 1'b0;
    check("sclr.phase", 32'(phase), 32'd0);
    check("sclr.sticky", 32'(miss_sticky), 32'd0);
    check("sclr.cw", 32'(cw), 32'(held));

    opcode = 4'b0010; flags = 2'b11; en = 1'b1;
    cycle("pre_arst");
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    #1 reset = 1'b1;

    write_row(5'd23, 7'b0000000, 7'b0000000, 13'h0ABC, 1'b1);
    for (int i = 0; i < 600; i++) begin
      opcode = 4'($urandom);
      flags = 2'($urandom);
      en = ($urandom_range(0, 99) < 75);
      sync_clr = ($urandom_range(0, 99) < 5);
      cfg_we = ($urandom_range(0, 99) < 30);
      cfg_idx = 5'($urandom_range(0, 25));
      cfg_match = 7'($urandom);
      cfg_mask = 7'($urandom & $urandom);
      cfg_cw = 13'($urandom);
      cfg_valid = ($urandom_range(0, 99) < 80);
      cycle("rnd");
    end
    cfg_we = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
